dtw_job_scheduler: RTL and testbench

Front-end controller for the DTW matching engine. It takes recognised-letter words from several gesture requesters, arbitrates them round-robin, and fetches the 20-entry candidate set for each job from the dictionary memory. It then clears, loads, starts and waits on the single shared engine, and returns the best-match word with the requester ID over a valid/ready response channel.

---
 rtl/dtw_pkg.sv | 26 ++
 rtl/dtw_job_scheduler_if.sv | 48 ++++
 rtl/dtw_rr_arbiter.sv | 45 ++++
 rtl/dtw_job_scheduler.sv | 163 ++++++++++++++++
 tb/tb_dtw_job_scheduler.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dtw_pkg.sv
// Shared types and constants for the DTW front-end: word layout, candidate count, scheduler states.
// A word is 15 chars of 8 bits, char 0 in the low byte, zero-padded.
package dtw_pkg;

  localparam int CHAR_NUM = 15;
  localparam int CHAR_W   = 8;
  localparam int WORD_W   = CHAR_NUM * CHAR_W;
  localparam int CAND_NUM = 20;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    CLR,
    FETCH,
    START,
    WAIT,
    RESP
  } state_t;

  function automatic logic is_empty_word(input word_t w);
    return (w == '0);
  endfunction

endpackage

// File: rtl/dtw_job_scheduler_if.sv
// Bundle of requester, dictionary, engine and response channels around the DTW job scheduler.
// The slave modport is the scheduler side; master is the environment side.
interface dtw_job_scheduler_if
  import dtw_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int BANK_W  = 4,
  parameter int ADDR_W  = 9
) ();

  logic [NUM_REQ-1:0]             i_req_valid;
  word_t [NUM_REQ-1:0]            i_req_word;
  logic [NUM_REQ-1:0][BANK_W-1:0] i_req_bank;
  logic [NUM_REQ-1:0]             o_req_ready;

  logic [ADDR_W-1:0]              o_dict_addr;
  logic                           o_dict_rd;
  word_t                          i_dict_data;

  logic                           o_eng_clr;
  logic                           o_eng_start;
  word_t                          o_eng_word;
  word_t [CAND_NUM-1:0]           o_eng_cand;
  logic                           i_eng_finish;
  word_t                          i_eng_word;

  logic                           o_rsp_valid;
  logic [1:0]                     o_rsp_id;
  word_t                          o_rsp_word;
  logic                           i_rsp_ready;

  logic                           o_busy;

  modport slave (
    input  i_req_valid, i_req_word, i_req_bank, i_dict_data,
    input  i_eng_finish, i_eng_word, i_rsp_ready,
    output o_req_ready, o_dict_addr, o_dict_rd, o_eng_clr, o_eng_start,
    output o_eng_word, o_eng_cand, o_rsp_valid, o_rsp_id, o_rsp_word, o_busy
  );

  modport master (
    output i_req_valid, i_req_word, i_req_bank, i_dict_data,
    output i_eng_finish, i_eng_word, i_rsp_ready,
    input  o_req_ready, o_dict_addr, o_dict_rd, o_eng_clr, o_eng_start,
    input  o_eng_word, o_eng_cand, o_rsp_valid, o_rsp_id, o_rsp_word, o_busy
  );

endinterface

// File: rtl/dtw_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr, wrapping modulo NUM_REQ.
// i_ptr must stay below NUM_REQ.
module dtw_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [1:0]         o_idx,
  output logic               o_any
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;

  function automatic logic [1:0] f_wrap(input logic [1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return 2'(s);
  endfunction

  // Rotate so bit 0 is the requester at the pointer; lowest set bit wins.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];

  always_comb begin
    o_any = 1'b0;
    o_idx = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_any = 1'b1;
        o_idx = f_wrap(i_ptr, i);
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      o_grant[j] = o_any && (o_idx == 2'(j));
    end
  end

endmodule

// File: rtl/dtw_job_scheduler.sv
// Arbitrates requesters, fetches 20 candidates per job, runs the shared DTW engine, returns the best match.
// Start 23 cycles after the grant cycle; the response is held until i_rsp_ready, with no new grant meanwhile.
module dtw_job_scheduler
  import dtw_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int BANK_W  = 4,
  parameter int ADDR_W  = 9
) (
  input logic              i_DTW_clk,
  input logic              i_DTW_rst_n,
  dtw_job_scheduler_if.slave bus
);

  state_t               r_state;
  logic [1:0]           r_rr_ptr;
  logic [1:0]           r_id;
  logic [ADDR_W-1:0]    r_base;
  logic [4:0]           r_k;
  word_t                r_word;
  word_t [CAND_NUM-1:0] r_cand;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic [ADDR_W-1:0]    r_dict_addr;
  logic                 r_dict_rd;
  logic                 r_eng_clr;
  logic                 r_eng_start;
  logic                 r_rsp_valid;
  logic [1:0]           r_rsp_id;
  word_t                r_rsp_word;
  logic                 r_busy;

  logic [NUM_REQ-1:0]   w_grant;
  logic [1:0]           w_gidx;
  logic                 w_any;
  word_t                w_sel_word;
  logic [BANK_W-1:0]    w_sel_bank;
  logic [1:0]           w_next_ptr;

  dtw_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (bus.i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_word = '0;
    w_sel_bank = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant[j]) begin
        w_sel_word = bus.i_req_word[j];
        w_sel_bank = bus.i_req_bank[j];
      end
    end
  end

  assign w_next_ptr = (w_gidx == 2'(NUM_REQ - 1)) ? 2'd0 : w_gidx + 2'd1;

  // Reset is active-high despite the _n suffix; it aborts any job in flight.
  always_ff @(posedge i_DTW_clk or posedge i_DTW_rst_n) begin
    if (i_DTW_rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= 2'd0;
      r_id        <= 2'd0;
      r_base      <= '0;
      r_k         <= 5'd0;
      r_word      <= '0;
      r_cand      <= '0;
      r_req_ready <= '0;
      r_dict_addr <= '0;
      r_dict_rd   <= 1'b0;
      r_eng_clr   <= 1'b0;
      r_eng_start <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 2'd0;
      r_rsp_word  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_req_ready <= '0;
      r_eng_clr   <= 1'b0;
      r_eng_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_req_ready <= w_grant;
            r_word      <= w_sel_word;
            r_base      <= ADDR_W'(w_sel_bank) * ADDR_W'(CAND_NUM);
            r_id        <= w_gidx;
            r_rr_ptr    <= w_next_ptr;
            r_busy      <= 1'b1;
            r_state     <= ARB;
          end
        end
        ARB: begin
          if (is_empty_word(r_word)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_word  <= '0;
            r_state     <= RESP;
          end else begin
            r_eng_clr <= 1'b1;
            r_state   <= CLR;
          end
        end
        CLR: begin
          r_dict_rd   <= 1'b1;
          r_dict_addr <= r_base;
          r_k         <= 5'd0;
          r_state     <= FETCH;
        end
        FETCH: begin
          // r_k counts FETCH cycles: read k issued at r_k=k, its data captured at r_k=k+1.
          if (r_k != 5'd0) r_cand[r_k - 5'd1] <= bus.i_dict_data;
          if (r_k < 5'(CAND_NUM - 1)) begin
            r_dict_addr <= r_base + ADDR_W'(r_k + 5'd1);
          end else begin
            r_dict_rd <= 1'b0;
          end
          if (r_k == 5'(CAND_NUM)) begin
            r_eng_start <= 1'b1;
            r_state     <= START;
          end
          r_k <= r_k + 5'd1;
        end
        START: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (bus.i_eng_finish) begin
            r_rsp_word  <= bus.i_eng_word;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (bus.i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_req_ready = r_req_ready;
  assign bus.o_dict_addr = r_dict_addr;
  assign bus.o_dict_rd   = r_dict_rd;
  assign bus.o_eng_clr   = r_eng_clr;
  assign bus.o_eng_start = r_eng_start;
  assign bus.o_eng_word  = r_word;
  assign bus.o_eng_cand  = r_cand;
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_id    = r_rsp_id;
  assign bus.o_rsp_word  = r_rsp_word;
  assign bus.o_busy      = r_busy;

endmodule

// File: tb/tb_dtw_job_scheduler.sv
// Directed bench for dtw_job_scheduler with a dictionary model and an engine model driven from the main flow.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_dtw_job_scheduler;
  import dtw_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int BANK_W  = 4;
  localparam int ADDR_W  = 9;

  localparam word_t W_CAT = 120'h544143;
  localparam word_t W_CAR = 120'h524143;
  localparam word_t W_DOG = 120'h474F44;
  localparam word_t W_HEN = 120'h4E4548;
  localparam word_t W_OWL = 120'h4C574F;
  localparam word_t W_EMU = 120'h554D45;
  localparam word_t W_ANT = 120'h544E41;
  localparam word_t W_BEE = 120'h454542;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dtw_job_scheduler_if #(.NUM_REQ(NUM_REQ), .BANK_W(BANK_W), .ADDR_W(ADDR_W)) bus ();

  dtw_job_scheduler #(.NUM_REQ(NUM_REQ), .BANK_W(BANK_W), .ADDR_W(ADDR_W)) dut (
    .i_DTW_clk   (clk),
    .i_DTW_rst_n (rst),
    .bus         (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int rd_q[$];
  int n_clr_tot = 0;
  int n_start_tot = 0;
  int n_rsp_tot = 0;

  function automatic word_t dict_word(input int a);
    return {8'hD1, 80'h0, 32'(a)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, 128'(bus.o_req_ready), 0);
    check({tag, "_busy"}, 128'(bus.o_busy), 0);
    check({tag, "_rsp_valid"}, 128'(bus.o_rsp_valid), 0);
    check({tag, "_strobes"}, 128'({bus.o_eng_clr, bus.o_eng_start, bus.o_dict_rd}), 0);
    check({tag, "_dict_addr"}, 128'(bus.o_dict_addr), 0);
    check({tag, "_eng_word"}, 128'(bus.o_eng_word), 0);
    check({tag, "_eng_cand_zero"}, 128'(bus.o_eng_cand == '0), 1);
    check({tag, "_rsp_id"}, 128'(bus.o_rsp_id), 0);
    check({tag, "_rsp_word"}, 128'(bus.o_rsp_word), 0);
  endtask

  // Dictionary: data for a read appears in the following cycle.
  initial begin
    logic rd;
    logic [ADDR_W-1:0] a;
    bus.i_dict_data = '0;
    forever begin
      @(negedge clk);
      rd = bus.o_dict_rd;
      a  = bus.o_dict_addr;
      if (rd) rd_q.push_back(int'(a));
      @(posedge clk);
      #1;
      bus.i_dict_data = rd ? dict_word(int'(a)) : '0;
    end
  end

  initial begin
    logic prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_eng_clr) n_clr_tot++;
      if (bus.o_eng_start) n_start_tot++;
      if (bus.o_rsp_valid && !prev_vld) n_rsp_tot++;
      prev_vld = bus.o_rsp_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // One full job from the grant cycle to the return to IDLE.
  task automatic run_job(input logic [1:0] exp_rdy, input logic drop, input word_t exp_word,
                         input int bank, input word_t result, input int wait_cyc, input int stall);
    int n, t_clr, t_start, n_clr;
    logic ok;
    logic [1:0] exp_id;
    word_t snap_w;
    word_t [CAND_NUM-1:0] snap_c;
    exp_id = (exp_rdy == 2'b10) ? 2'd1 : 2'd0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_req_ready == '0 && n < 50);
    check("grant", 128'(bus.o_req_ready), 128'(exp_rdy));
    check("grant_lat", 128'(n), 1);
    if (drop) bus.i_req_valid[exp_id] = 1'b0;
    rd_q.delete();
    t_clr = -1; t_start = -1; n_clr = 0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (t == 1) check("ready_pulse", 128'(bus.o_req_ready), 0);
      if (bus.o_eng_clr) begin
        n_clr++;
        if (t_clr < 0) t_clr = t;
      end
      if (bus.o_eng_start) begin
        t_start = t;
        break;
      end
    end
    check("clr_cycle", 128'(t_clr), 1);
    check("clr_width", 128'(n_clr), 1);
    // Counting the ARB cycle as cycle 1, start lands in cycle 24.
    check("start_cycle", 128'(t_start), 23);
    check("rd_count", 128'(rd_q.size()), 20);
    ok = 1'b1;
    foreach (rd_q[k]) if (rd_q[k] != bank * 20 + k) ok = 1'b0;
    check("rd_addrs", 128'(ok), 1);
    ok = 1'b1;
    for (int k = 0; k < CAND_NUM; k++) if (bus.o_eng_cand[k] !== dict_word(bank * 20 + k)) ok = 1'b0;
    check("cand_data", 128'(ok), 1);
    check("eng_word", 128'(bus.o_eng_word), 128'(exp_word));
    snap_w = bus.o_eng_word;
    snap_c = bus.o_eng_cand;
    ok = 1'b1;
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      if (bus.o_eng_word !== snap_w || bus.o_eng_cand !== snap_c) ok = 1'b0;
    end
    bus.i_rsp_ready  = (stall == 0);
    bus.i_eng_finish = 1'b1;
    bus.i_eng_word   = result;
    @(negedge clk);
    if (bus.o_eng_word !== snap_w || bus.o_eng_cand !== snap_c) ok = 1'b0;
    check("eng_stable", 128'(ok), 1);
    bus.i_eng_finish = 1'b0;
    bus.i_eng_word   = '0;
    check("rsp_valid", 128'(bus.o_rsp_valid), 1);
    check("rsp_id", 128'(bus.o_rsp_id), 128'(exp_id));
    check("rsp_word", 128'(bus.o_rsp_word), 128'(result));
    if (stall > 0) begin
      ok = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (!(bus.o_rsp_valid === 1'b1 && bus.o_rsp_id === exp_id &&
              bus.o_rsp_word === result && bus.o_req_ready === '0)) ok = 1'b0;
      end
      check("stall_hold", 128'(ok), 1);
      bus.i_rsp_ready = 1'b1;
    end
    @(negedge clk);
    check("rsp_drop", 128'(bus.o_rsp_valid), 0);
    check("idle_busy", 128'(bus.o_busy), 0);
  endtask

  initial begin
    int n, c0, s0, r0;
    bus.i_req_valid  = '0;
    bus.i_req_word   = '0;
    bus.i_req_bank   = '0;
    bus.i_eng_finish = 1'b0;
    bus.i_eng_word   = '0;
    bus.i_rsp_ready  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    // A finish pulse while idle must be ignored.
    bus.i_eng_finish = 1'b1;
    bus.i_eng_word   = W_CAR;
    @(negedge clk);
    bus.i_eng_finish = 1'b0;
    bus.i_eng_word   = '0;
    @(negedge clk);
    check("stray_finish_rsp", 128'(bus.o_rsp_valid), 0);
    check("stray_finish_busy", 128'(bus.o_busy), 0);

    // Single request "CAT" from bank 2, engine answers "CAR".
    bus.i_rsp_ready   = 1'b1;
    bus.i_req_word[0] = W_CAT;
    bus.i_req_bank[0] = 4'd2;
    bus.i_req_valid[0] = 1'b1;
    run_job(2'b01, 1'b1, W_CAT, 2, W_CAR, 3, 0);

    // Empty query from requester 1 bypasses the engine.
    c0 = n_clr_tot; s0 = n_start_tot;
    bus.i_req_word[1] = '0;
    bus.i_req_bank[1] = 4'd0;
    bus.i_req_valid[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_req_ready == '0 && n < 20);
    check("empty_grant", 128'(bus.o_req_ready), 128'(2'b10));
    bus.i_req_valid[1] = 1'b0;
    @(negedge clk);
    check("empty_rsp_valid", 128'(bus.o_rsp_valid), 1);
    check("empty_rsp_id", 128'(bus.o_rsp_id), 1);
    check("empty_rsp_word", 128'(bus.o_rsp_word), 0);
    @(negedge clk);
    check("empty_rsp_drop", 128'(bus.o_rsp_valid), 0);
    check("empty_no_clr", 128'(n_clr_tot - c0), 0);
    check("empty_no_start", 128'(n_start_tot - s0), 0);

    // Both requesters valid: grants alternate 0, 1, 0, 1.
    bus.i_req_word[0] = W_DOG;
    bus.i_req_bank[0] = 4'd1;
    bus.i_req_word[1] = W_HEN;
    bus.i_req_bank[1] = 4'd3;
    bus.i_req_valid   = 2'b11;
    run_job(2'b01, 1'b0, W_DOG, 1, 120'hA1, 2, 0);
    run_job(2'b10, 1'b0, W_HEN, 3, 120'hB2, 4, 0);
    run_job(2'b01, 1'b0, W_DOG, 1, 120'hC3, 1, 0);
    run_job(2'b10, 1'b0, W_HEN, 3, 120'hD4, 6, 0);
    bus.i_req_valid = 2'b00;

    // Response stalled 10 cycles while requester 1 waits.
    bus.i_req_word[0] = W_OWL;
    bus.i_req_bank[0] = 4'd5;
    bus.i_req_word[1] = W_EMU;
    bus.i_req_bank[1] = 4'd6;
    bus.i_req_valid   = 2'b11;
    run_job(2'b01, 1'b1, W_OWL, 5, 120'hE5, 3, 10);
    run_job(2'b10, 1'b1, W_EMU, 6, 120'hF6, 2, 0);

    // Reset during FETCH at k = 7 aborts the job.
    r0 = n_rsp_tot;
    bus.i_req_word[0] = W_ANT;
    bus.i_req_bank[0] = 4'd7;
    bus.i_req_valid[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_req_ready == '0 && n < 20);
    check("abort_grant", 128'(bus.o_req_ready), 128'(2'b01));
    bus.i_req_valid[0] = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_at_k7", 128'({bus.o_dict_rd, bus.o_dict_addr}), 128'({1'b1, 9'd147}));
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("after_abort");
    bus.i_req_word[1] = W_BEE;
    bus.i_req_bank[1] = 4'd0;
    bus.i_req_valid[1] = 1'b1;
    run_job(2'b10, 1'b1, W_BEE, 0, 120'h77, 5, 0);
    check("abort_no_rsp", 128'(n_rsp_tot - r0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
